// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants for the accumulator CPU control unit
//
// Purpose: opcode values, bus-source encodings and T-state names shared by
//          the control unit and its sequence counter.
// Ports:   none (package).
package cpu_pkg;

   localparam int SC_W = 3;

   // Opcodes carried in IR[6:4]
   localparam logic [2:0] OP_ADD    = 3'd0;
   localparam logic [2:0] OP_ASHL   = 3'd1;
   localparam logic [2:0] OP_XNOR   = 3'd2;
   localparam logic [2:0] OP_DIV2   = 3'd3;
   localparam logic [2:0] OP_LOAD   = 3'd4;
   localparam logic [2:0] OP_STORE  = 3'd5;
   localparam logic [2:0] OP_COMP2S = 3'd6;
   localparam logic [2:0] OP_HALT   = 3'd7;

   // Bus source select; codes 6 and 7 are unused
   localparam logic [2:0] BUS_MEM = 3'd0;
   localparam logic [2:0] BUS_AR  = 3'd1;
   localparam logic [2:0] BUS_PC  = 3'd2;
   localparam logic [2:0] BUS_DR  = 3'd3;
   localparam logic [2:0] BUS_AC  = 3'd4;
   localparam logic [2:0] BUS_IR  = 3'd5;

   // Timing states held in the sequence counter; 6 and 7 are unreachable
   typedef enum logic [SC_W-1:0] {
      T0 = 3'd0,
      T1 = 3'd1,
      T2 = 3'd2,
      T3 = 3'd3,
      T4 = 3'd4,
      T5 = 3'd5
   } t_state_t;

endpackage

// File: rtl/seq_counter.sv
// rtl/seq_counter.sv - sequence counter with async reset, sync clear, hold and increment
//
// Purpose: holds the current T-state of the control unit.
// Ports:   clk   - rising-edge clock
//          clr   - asynchronous active-high reset to 0
//          clear - synchronous return to 0 (wins over inc)
//          inc   - advance by one; with neither clear nor inc the count holds
//          count - current sequence count
module seq_counter #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/cpu_control_unit.sv
// rtl/cpu_control_unit.sv - timing and control sequencer for the 8-bit accumulator CPU
//
// Purpose: steps T0..T5, decodes IR into register strobes, bus select, ALU
//          opcode and memory read/write; supports HALT and mem_ready waits.
// Ports:   clk, clr (async active-high reset), run (allow new instruction),
//          mem_ready (memory completes this cycle), ir (datapath IR);
//          busSEL, aluOpcode, read, write, loadIR/AR/DR/AC, incPC, clrPC,
//          sc (current count), halted.
module cpu_control_unit
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8,
   parameter int OP_W   = 3
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              run,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] ir,
   output logic [2:0]        busSEL,
   output logic [OP_W-1:0]   aluOpcode,
   output logic              read,
   output logic              write,
   output logic              loadIR,
   output logic              loadAR,
   output logic              loadDR,
   output logic              loadAC,
   output logic              incPC,
   output logic              clrPC,
   output logic [SC_W-1:0]   sc,
   output logic              halted
);

   logic [OP_W-1:0] op;
   logic            ind;
   logic            cnt_clear;
   logic            cnt_inc;
   logic            set_halt;
   logic            unused_addr;

   assign op  = ir[DATA_W-2 -: OP_W];
   assign ind = ir[DATA_W-1];

   // The address field is consumed by the datapath over the bus, not here
   assign unused_addr = ^ir[ADDR_W-1:0];

   assign clrPC = clr;

   seq_counter #(.W(SC_W)) u_seq (
      .clk   (clk),
      .clr   (clr),
      .clear (cnt_clear),
      .inc   (cnt_inc),
      .count (sc)
   );

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         halted <= 1'b0;
      end else if (set_halt) begin
         halted <= 1'b1;
      end
   end

   always_comb begin
      busSEL    = BUS_MEM;
      aluOpcode = '0;
      read      = 1'b0;
      write     = 1'b0;
      loadIR    = 1'b0;
      loadAR    = 1'b0;
      loadDR    = 1'b0;
      loadAC    = 1'b0;
      incPC     = 1'b0;
      cnt_clear = 1'b0;
      cnt_inc   = 1'b0;
      set_halt  = 1'b0;

      // Outputs are forced quiet for the whole time clr is high, even though
      // sc already reads 0, so T0's loadAR cannot leak out during reset.
      if (!clr) begin
         case (sc)
            T0: begin
               busSEL = BUS_PC;
               if (run && !halted) begin
                  loadAR  = 1'b1;
                  cnt_inc = 1'b1;
               end
            end
            T1: begin
               read = 1'b1;
               if (mem_ready) begin
                  loadIR  = 1'b1;
                  incPC   = 1'b1;
                  cnt_inc = 1'b1;
               end
            end
            T2: begin
               if (op == OP_HALT) begin
                  set_halt  = 1'b1;
                  cnt_clear = 1'b1;
               end else begin
                  busSEL  = BUS_IR;
                  loadAR  = 1'b1;
                  cnt_inc = 1'b1;
               end
            end
            T3: begin
               // Direct instructions still spend one idle cycle here so both
               // addressing modes share the same zero-wait latency.
               if (ind) begin
                  read = 1'b1;
                  if (mem_ready) begin
                     loadAR  = 1'b1;
                     cnt_inc = 1'b1;
                  end
               end else begin
                  cnt_inc = 1'b1;
               end
            end
            T4: begin
               if (op == OP_STORE) begin
                  busSEL = BUS_AC;
                  write  = 1'b1;
                  if (mem_ready) begin
                     cnt_clear = 1'b1;
                  end
               end else begin
                  read = 1'b1;
                  if (mem_ready) begin
                     loadDR  = 1'b1;
                     cnt_inc = 1'b1;
                  end
               end
            end
            T5: begin
               aluOpcode = op;
               loadAC    = 1'b1;
               cnt_clear = 1'b1;
            end
            default: begin
               // Unreachable counts 6/7: recover to T0 silently
               cnt_clear = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb/tb_cpu_control_unit.sv - self-checking bench for cpu_control_unit
module tb_cpu_control_unit;

   localparam logic [2:0] B_MEM = 3'd0;
   localparam logic [2:0] B_PC  = 3'd2;
   localparam logic [2:0] B_AC  = 3'd4;
   localparam logic [2:0] B_IR  = 3'd5;

   // load masks {IR, AR, DR, AC}
   localparam logic [3:0] L_NO = 4'b0000;
   localparam logic [3:0] L_IR = 4'b1000;
   localparam logic [3:0] L_AR = 4'b0100;
   localparam logic [3:0] L_DR = 4'b0010;
   localparam logic [3:0] L_AC = 4'b0001;

   logic       clk = 1'b0;
   logic       clr;
   logic       run;
   logic       mem_ready;
   logic [7:0] ir;
   logic [2:0] busSEL;
   logic [2:0] aluOpcode;
   logic       read, write;
   logic       loadIR, loadAR, loadDR, loadAC;
   logic       incPC, clrPC;
   logic [2:0] sc;
   logic       halted;

   cpu_control_unit dut (
      .clk       (clk),
      .clr       (clr),
      .run       (run),
      .mem_ready (mem_ready),
      .ir        (ir),
      .busSEL    (busSEL),
      .aluOpcode (aluOpcode),
      .read      (read),
      .write     (write),
      .loadIR    (loadIR),
      .loadAR    (loadAR),
      .loadDR    (loadDR),
      .loadAC    (loadAC),
      .incPC     (incPC),
      .clrPC     (clrPC),
      .sc        (sc),
      .halted    (halted)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0]  ir;
      logic        run;
      logic        mr;
      logic [17:0] exp;
   } vec_t;
   vec_t tbl[$];

   typedef struct {
      logic [2:0] t;
      logic [2:0] bus;
      logic       rd;
      logic       wr;
      logic [3:0] ld;
      logic       inc;
      logic [2:0] alu;
      logic       waits;
      logic       halt;
   } step_t;
   step_t plan[$];
   int    pos;
   logic  m_halted;
   logic [7:0] cur_ir;

   function automatic logic [17:0] mk(input logic [2:0] bus, input logic [2:0] alu,
                                      input logic rd, input logic wr, input logic [3:0] ld,
                                      input logic inc, input logic cp, input logic [2:0] s,
                                      input logic h);
      return {bus, alu, rd, wr, ld, inc, cp, s, h};
   endfunction

   function automatic logic [17:0] act();
      return {busSEL, aluOpcode, read, write, loadIR, loadAR, loadDR, loadAC,
              incPC, clrPC, sc, halted};
   endfunction

   task automatic check(input string nm, input logic [17:0] a, input logic [17:0] e);
      n_checks++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got bus/alu/rd/wr/ld/inc/clrpc/sc/h=%b required %b (t=%0t)",
                  nm, a, e, $time);
      end
   endtask

   task automatic step(input string nm, input logic [7:0] i_v, input logic r,
                       input logic m, input logic c, input logic [17:0] e);
      @(posedge clk);
      #1;
      ir = i_v; run = r; mem_ready = m; clr = c;
      #1;
      check(nm, act(), e);
   endtask

   // Instruction plan derived from the instruction's meaning: fetch, address,
   // optional indirection, operand access, then ALU write-back.
   task automatic build_plan(input logic [7:0] v);
      logic [2:0] op;
      op = v[6:4];
      plan.delete();
      plan.push_back('{3'd0, B_PC,  1'b0, 1'b0, L_AR, 1'b0, 3'd0, 1'b0, 1'b0});
      plan.push_back('{3'd1, B_MEM, 1'b1, 1'b0, L_IR, 1'b1, 3'd0, 1'b1, 1'b0});
      if (op == 3'd7) begin
         plan.push_back('{3'd2, B_MEM, 1'b0, 1'b0, L_NO, 1'b0, 3'd0, 1'b0, 1'b1});
      end else begin
         plan.push_back('{3'd2, B_IR, 1'b0, 1'b0, L_AR, 1'b0, 3'd0, 1'b0, 1'b0});
         if (v[7])
            plan.push_back('{3'd3, B_MEM, 1'b1, 1'b0, L_AR, 1'b0, 3'd0, 1'b1, 1'b0});
         else
            plan.push_back('{3'd3, B_MEM, 1'b0, 1'b0, L_NO, 1'b0, 3'd0, 1'b0, 1'b0});
         if (op == 3'd5) begin
            plan.push_back('{3'd4, B_AC, 1'b0, 1'b1, L_NO, 1'b0, 3'd0, 1'b1, 1'b0});
         end else begin
            plan.push_back('{3'd4, B_MEM, 1'b1, 1'b0, L_DR, 1'b0, 3'd0, 1'b1, 1'b0});
            plan.push_back('{3'd5, B_MEM, 1'b0, 1'b0, L_AC, 1'b0, op, 1'b0, 1'b0});
         end
      end
   endtask

   task automatic model_cycle(input logic c, input logic r, input logic m,
                              output logic [17:0] e, output logic ld_ir);
      step_t      s;
      logic       stall;
      logic [3:0] ld;
      logic       inc;
      ld_ir = 1'b0;
      if (c) begin
         e = mk(B_MEM, 3'd0, 1'b0, 1'b0, L_NO, 1'b0, 1'b1, 3'd0, 1'b0);
         pos = 0;
         m_halted = 1'b0;
      end else begin
         build_plan(cur_ir);
         if (pos == 0 && (!r || m_halted)) begin
            e = mk(B_PC, 3'd0, 1'b0, 1'b0, L_NO, 1'b0, 1'b0, 3'd0, m_halted);
         end else begin
            s     = plan[pos];
            stall = s.waits && !m;
            ld    = stall ? L_NO : s.ld;
            inc   = stall ? 1'b0 : s.inc;
            e     = mk(s.bus, s.alu, s.rd, s.wr, ld, inc, 1'b0, s.t, m_halted);
            ld_ir = ld[3];
            if (!stall) begin
               if (pos == plan.size() - 1) begin
                  pos = 0;
                  if (s.halt) m_halted = 1'b1;
               end else begin
                  pos++;
               end
            end
         end
      end
   endtask

   function automatic logic [7:0] rand_instr();
      logic [7:0] v;
      v = 8'($urandom);
      if ($urandom_range(0, 11) == 0) v[6:4] = 3'd7;
      else                            v[6:4] = 3'($urandom_range(0, 6));
      return v;
   endfunction

   task automatic add_row(input logic [7:0] i_v, input logic r, input logic m,
                          input logic [17:0] e);
      vec_t v;
      v.ir = i_v; v.run = r; v.mr = m; v.exp = e;
      tbl.push_back(v);
   endtask

   initial begin
      logic [17:0] e;
      logic        ld_ir;
      logic        load_pending;
      logic        r_clr, r_run, r_mr;
      int          halt_wait;

      clr = 1'b1; run = 1'b0; mem_ready = 1'b0; ir = 8'h00;
      #3;
      check("reset", act(), mk(B_MEM, 3'd0, 1'b0, 1'b0, L_NO, 1'b0, 1'b1, 3'd0, 1'b0));

      // ADD direct
      add_row(8'h03, 1, 1, mk(B_PC,  0, 0, 0, L_AR, 0, 0, 0, 0));
      add_row(8'h03, 1, 1, mk(B_MEM, 0, 1, 0, L_IR, 1, 0, 1, 0));
      add_row(8'h03, 1, 1, mk(B_IR,  0, 0, 0, L_AR, 0, 0, 2, 0));
      add_row(8'h03, 1, 1, mk(B_MEM, 0, 0, 0, L_NO, 0, 0, 3, 0));
      add_row(8'h03, 1, 1, mk(B_MEM, 0, 1, 0, L_DR, 0, 0, 4, 0));
      add_row(8'h03, 1, 1, mk(B_MEM, 0, 0, 0, L_AC, 0, 0, 5, 0));
      // LOAD indirect, two wait states in T3
      add_row(8'hC5, 1, 1, mk(B_PC,  0, 0, 0, L_AR, 0, 0, 0, 0));
      add_row(8'hC5, 1, 1, mk(B_MEM, 0, 1, 0, L_IR, 1, 0, 1, 0));
      add_row(8'hC5, 1, 1, mk(B_IR,  0, 0, 0, L_AR, 0, 0, 2, 0));
      add_row(8'hC5, 1, 0, mk(B_MEM, 0, 1, 0, L_NO, 0, 0, 3, 0));
      add_row(8'hC5, 1, 0, mk(B_MEM, 0, 1, 0, L_NO, 0, 0, 3, 0));
      add_row(8'hC5, 1, 1, mk(B_MEM, 0, 1, 0, L_AR, 0, 0, 3, 0));
      add_row(8'hC5, 1, 1, mk(B_MEM, 0, 1, 0, L_DR, 0, 0, 4, 0));
      add_row(8'hC5, 1, 1, mk(B_MEM, 4, 0, 0, L_AC, 0, 0, 5, 0));
      // STORE direct with one write wait, then park with run=0
      add_row(8'h5A, 1, 1, mk(B_PC,  0, 0, 0, L_AR, 0, 0, 0, 0));
      add_row(8'h5A, 1, 1, mk(B_MEM, 0, 1, 0, L_IR, 1, 0, 1, 0));
      add_row(8'h5A, 1, 1, mk(B_IR,  0, 0, 0, L_AR, 0, 0, 2, 0));
      add_row(8'h5A, 1, 1, mk(B_MEM, 0, 0, 0, L_NO, 0, 0, 3, 0));
      add_row(8'h5A, 1, 0, mk(B_AC,  0, 0, 1, L_NO, 0, 0, 4, 0));
      add_row(8'h5A, 1, 1, mk(B_AC,  0, 0, 1, L_NO, 0, 0, 4, 0));
      add_row(8'h5A, 0, 1, mk(B_PC,  0, 0, 0, L_NO, 0, 0, 0, 0));
      // HALT
      add_row(8'h70, 1, 1, mk(B_PC,  0, 0, 0, L_AR, 0, 0, 0, 0));
      add_row(8'h70, 1, 1, mk(B_MEM, 0, 1, 0, L_IR, 1, 0, 1, 0));
      add_row(8'h70, 1, 1, mk(B_MEM, 0, 0, 0, L_NO, 0, 0, 2, 0));
      add_row(8'h70, 1, 1, mk(B_PC,  0, 0, 0, L_NO, 0, 0, 0, 1));

      foreach (tbl[k]) step($sformatf("table[%0d]", k), tbl[k].ir, tbl[k].run, tbl[k].mr,
                            1'b0, tbl[k].exp);

      // Halted: run ignored, no fetch for 20 cycles
      for (int k = 0; k < 20; k++)
         step("halt_hold", 8'h70, 1'b1, 1'($urandom), 1'b0,
              mk(B_PC, 0, 0, 0, L_NO, 0, 0, 0, 1));

      // clr releases HALT asynchronously
      @(posedge clk);
      #3 clr = 1'b1;
      #1 check("halt_clr", act(), mk(B_MEM, 0, 0, 0, L_NO, 0, 1, 0, 0));

      // Fetch resumes; run dropped during T4 of ADD
      step("resume_t0", 8'h03, 1, 1, 0, mk(B_PC,  0, 0, 0, L_AR, 0, 0, 0, 0));
      step("resume_t1", 8'h03, 1, 1, 0, mk(B_MEM, 0, 1, 0, L_IR, 1, 0, 1, 0));
      step("resume_t2", 8'h03, 1, 1, 0, mk(B_IR,  0, 0, 0, L_AR, 0, 0, 2, 0));
      step("resume_t3", 8'h03, 1, 1, 0, mk(B_MEM, 0, 0, 0, L_NO, 0, 0, 3, 0));
      step("rundrop_t4", 8'h03, 0, 1, 0, mk(B_MEM, 0, 1, 0, L_DR, 0, 0, 4, 0));
      step("rundrop_t5", 8'h03, 0, 1, 0, mk(B_MEM, 0, 0, 0, L_AC, 0, 0, 5, 0));
      for (int k = 0; k < 3; k++)
         step("rundrop_park", 8'h03, 0, 1, 0, mk(B_PC, 0, 0, 0, L_NO, 0, 0, 0, 0));

      // Async clr in T4 while waiting on memory
      step("abort_t0", 8'h03, 1, 1, 0, mk(B_PC,  0, 0, 0, L_AR, 0, 0, 0, 0));
      step("abort_t1", 8'h03, 1, 1, 0, mk(B_MEM, 0, 1, 0, L_IR, 1, 0, 1, 0));
      step("abort_t2", 8'h03, 1, 1, 0, mk(B_IR,  0, 0, 0, L_AR, 0, 0, 2, 0));
      step("abort_t3", 8'h03, 1, 1, 0, mk(B_MEM, 0, 0, 0, L_NO, 0, 0, 3, 0));
      step("abort_t4w", 8'h03, 1, 0, 0, mk(B_MEM, 0, 1, 0, L_NO, 0, 0, 4, 0));
      #1 clr = 1'b1;
      #1 check("abort_async", act(), mk(B_MEM, 0, 0, 0, L_NO, 0, 1, 0, 0));
      // run=0 after reset: parked at T0, no fetch
      for (int k = 0; k < 4; k++)
         step("run0_park", 8'h03, 0, 1, 0, mk(B_PC, 0, 0, 0, L_NO, 0, 0, 0, 0));

      // Randomized run against the instruction-level model
      pos = 0; m_halted = 1'b0; cur_ir = rand_instr();
      load_pending = 1'b0; halt_wait = 0;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         #1;
         if (load_pending) cur_ir = rand_instr();
         r_clr = (m_halted && halt_wait >= 4) || ($urandom_range(0, 199) == 0);
         r_run = ($urandom_range(0, 99) < 85);
         r_mr  = ($urandom_range(0, 99) < 70);
         ir = cur_ir; run = r_run; mem_ready = r_mr; clr = r_clr;
         #1;
         model_cycle(r_clr, r_run, r_mr, e, ld_ir);
         load_pending = ld_ir;
         check("random", act(), e);
         halt_wait = m_halted ? halt_wait + 1 : 0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
